text_pixel_pipeline: RTL and testbench

- Text-mode renderer stage directly upstream of the font ROM, which it drives with codepoint/row; it also consumes the returned bitmap row.
- Takes raster position and sync from the video timing generator and fetches the character/attribute word from the text buffer BRAM.
- Addresses the font ROM, which must be instantiated with ASYNC=0 (1-cycle latency).
- Emits one pixel per clock with aligned syncs, colour indices and a blinking underline cursor.
- Sits between the timing generator and the palette/DAC output stage.

---
 rtl/text_pixel_pipeline.sv | 154 +++++++++++++++
 tb/tb_text_pixel_pipeline.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel pipeline: raster position -> text buffer -> font ROM -> pixel with colour indices.
// Fixed 3-cycle latency from pix_* to outputs; syncs and active travel with the pixel.
module text_pixel_pipeline #(
    parameter int FONT_WIDTH   = 8,
    parameter int FONT_HEIGHT  = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int H_BITS       = 10,
    parameter int V_BITS       = 10,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [H_BITS-1:0]              pix_x,
    input  logic [V_BITS-1:0]              pix_y,
    input  logic                           pix_active,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    output logic [$clog2(COLS*ROWS)-1:0]   tb_addr,
    input  logic [15:0]                    tb_data,
    output logic [7:0]                     font_codepoint,
    output logic [$clog2(FONT_HEIGHT)-1:0] font_row,
    input  logic [FONT_WIDTH-1:0]          font_bitmap,
    input  logic [$clog2(COLS)-1:0]        cursor_col,
    input  logic [$clog2(ROWS)-1:0]        cursor_row,
    input  logic                           cursor_en,
    output logic                           pixel_on,
    output logic [3:0]                     fg_idx,
    output logic [3:0]                     bg_idx,
    output logic                           active_out,
    output logic                           hsync_out,
    output logic                           vsync_out
);

    localparam int AW  = $clog2(COLS*ROWS);
    localparam int PXW = $clog2(FONT_WIDTH);
    localparam int RW  = $clog2(FONT_HEIGHT);
    localparam int FCW = $clog2(BLINK_FRAMES);

    logic [H_BITS-1:0] cx;
    logic [V_BITS-1:0] cy;
    logic [PXW-1:0]    px;
    logic [RW-1:0]     py;
    logic              in_grid;
    logic              cursor_hit;
    logic [AW-1:0]     addr_lin;

    logic              vs_q;
    logic              arm_q;
    logic              vs_rise;
    logic              blink_phase;
    logic [FCW-1:0]    frame_cnt;

    logic              vld_p1, cur_p1, hs_p1, vs_p1;
    logic [PXW-1:0]    px_p1;
    logic [RW-1:0]     py_p1;
    logic              vld_p2, cur_p2, hs_p2, vs_p2;
    logic [PXW-1:0]    px_p2;
    logic [3:0]        fg_p2, bg_p2;
    logic [PXW-1:0]    bit_sel;
    logic              glyph_bit;

    // Stage T: cell decomposition, buffer address and cursor test
    assign cx = pix_x / H_BITS'(FONT_WIDTH);
    assign cy = pix_y / V_BITS'(FONT_HEIGHT);
    assign px = PXW'(pix_x % H_BITS'(FONT_WIDTH));
    assign py = RW'(pix_y % V_BITS'(FONT_HEIGHT));

    assign in_grid  = pix_active & (cx < H_BITS'(COLS)) & (cy < V_BITS'(ROWS));
    assign addr_lin = AW'(cy) * AW'(COLS) + AW'(cx);
    assign tb_addr  = in_grid ? addr_lin : '0;

    assign cursor_hit = cursor_en & ~blink_phase
                      & (cx == H_BITS'(cursor_col)) & (cy == V_BITS'(cursor_row))
                      & (py >= RW'(FONT_HEIGHT-2));

    // Blink timer: the first clock after reset release never counts an edge
    assign vs_rise = vsync_in & ~vs_q & arm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            arm_q       <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vs_q  <= vsync_in;
            arm_q <= 1'b1;
            if (vs_rise) begin
                if (frame_cnt == FCW'(BLINK_FRAMES-1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FCW'(1);
                end
            end
        end
    end

    // Stage p1: buffer word arrives, font ROM addressed
    assign font_codepoint = tb_data[7:0];
    assign font_row       = py_p1;

    // Stage p2: bitmap row arrives, MSB is the leftmost pixel
    assign bit_sel   = PXW'(FONT_WIDTH-1) - px_p2;
    assign glyph_bit = font_bitmap[bit_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            cur_p1     <= 1'b0;
            hs_p1      <= 1'b0;
            vs_p1      <= 1'b0;
            px_p1      <= '0;
            py_p1      <= '0;
            vld_p2     <= 1'b0;
            cur_p2     <= 1'b0;
            hs_p2      <= 1'b0;
            vs_p2      <= 1'b0;
            px_p2      <= '0;
            fg_p2      <= '0;
            bg_p2      <= '0;
            pixel_on   <= 1'b0;
            fg_idx     <= '0;
            bg_idx     <= '0;
            active_out <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
        end else begin
            vld_p1     <= in_grid;
            cur_p1     <= cursor_hit;
            hs_p1      <= hsync_in;
            vs_p1      <= vsync_in;
            px_p1      <= px;
            py_p1      <= py;

            vld_p2     <= vld_p1;
            cur_p2     <= cur_p1;
            hs_p2      <= hs_p1;
            vs_p2      <= vs_p1;
            px_p2      <= px_p1;
            fg_p2      <= tb_data[11:8];
            bg_p2      <= tb_data[15:12];

            pixel_on   <= vld_p2 & (glyph_bit | cur_p2);
            fg_idx     <= vld_p2 ? fg_p2 : 4'h0;
            bg_idx     <= vld_p2 ? bg_p2 : 4'h0;
            active_out <= vld_p2;
            hsync_out  <= hs_p2;
            vsync_out  <= vs_p2;
        end
    end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Bench for text_pixel_pipeline: BRAM and font ROM models with 1-cycle reads,
// behavioural pixel model feeding a 3-deep expectation queue.
module tb_text_pixel_pipeline;

    localparam int FW = 8;
    localparam int FH = 16;
    localparam int NC = 80;
    localparam int NR = 30;

    typedef struct {
        int x;
        int y;
        bit act;
        bit hs;
        bit vs;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x, pix_y;
    logic        pix_active, hsync_in, vsync_in;
    logic [11:0] tb_addr;
    logic [15:0] tb_data;
    logic [7:0]  font_codepoint;
    logic [3:0]  font_row;
    logic [7:0]  font_bitmap;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_en;
    logic        pixel_on;
    logic [3:0]  fg_idx, bg_idx;
    logic        active_out, hsync_out, vsync_out;
    logic [11:0] obs;

    logic [15:0] tbuf [0:4095];
    logic [7:0]  fmem [0:4095];

    logic [11:0] exp_q [$];
    stim_t       stim_q [$];
    int          checks = 0;
    int          passed = 0;

    bit          blink_exp, armed, prev_vs;
    int          frame_exp;

    always #5 clk = ~clk;

    text_pixel_pipeline dut (
        .clk(clk), .rst_n(rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .tb_addr(tb_addr), .tb_data(tb_data),
        .font_codepoint(font_codepoint), .font_row(font_row), .font_bitmap(font_bitmap),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .pixel_on(pixel_on), .fg_idx(fg_idx), .bg_idx(bg_idx),
        .active_out(active_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    assign obs = {pixel_on, fg_idx, bg_idx, active_out, hsync_out, vsync_out};

    always @(posedge clk) begin
        tb_data     <= tbuf[tb_addr];
        font_bitmap <= fmem[{font_codepoint, font_row}];
    end

    function automatic stim_t mk(input int x, input int y, input bit act, input bit hs, input bit vs);
        stim_t s;
        s.x = x; s.y = y; s.act = act; s.hs = hs; s.vs = vs;
        return s;
    endfunction

    function automatic int exp_addr(input stim_t s);
        int cx, cy;
        cx = s.x / FW;
        cy = s.y / FH;
        if (s.act && cx < NC && cy < NR) return cy * NC + cx;
        return 0;
    endfunction

    function automatic logic [11:0] model(input stim_t s);
        int cx, px, cy, py;
        logic [15:0] w;
        logic [7:0]  bm;
        logic        b, cur;
        cx = s.x / FW; px = s.x % FW;
        cy = s.y / FH; py = s.y % FH;
        if (!(s.act && cx < NC && cy < NR)) return {10'd0, s.hs, s.vs};
        w   = tbuf[cy * NC + cx];
        bm  = fmem[int'(w[7:0]) * FH + py];
        b   = bm[7 - px];
        cur = cursor_en && !blink_exp && cx == int'(cursor_col) && cy == int'(cursor_row) && py >= FH - 2;
        return {b | cur, w[11:8], w[15:12], 1'b1, s.hs, s.vs};
    endfunction

    task automatic model_reset();
        blink_exp = 0; frame_exp = 0; armed = 0; prev_vs = 0;
        exp_q.delete();
    endtask

    task automatic drive(input stim_t s, input bit push);
        pix_x      = s.x[9:0];
        pix_y      = s.y[9:0];
        pix_active = s.act;
        hsync_in   = s.hs;
        vsync_in   = s.vs;
        if (push) exp_q.push_back(model(s));
        if (s.vs && !prev_vs && armed) begin
            if (frame_exp == 31) begin
                frame_exp = 0;
                blink_exp = !blink_exp;
            end else begin
                frame_exp++;
            end
        end
        armed   = 1;
        prev_vs = s.vs;
    endtask

    task automatic add_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            stim_q.push_back(mk(0, 0, 0, 0, 1));
            stim_q.push_back(mk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset();
        logic [11:0] e;
        int n;
        rst_n = 1'b0;
        cursor_en = 0; cursor_col = 0; cursor_row = 0;
        for (int i = 0; i < 5; i++) begin
            pix_x = 10'($urandom); pix_y = 10'($urandom);
            pix_active = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (obs !== 12'h000) $display("FAIL reset_hold: got %h expected 000", obs);
            else passed++;
        end
        rst_n = 1'b1;
        model_reset();
        stim_q.delete();
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        stim_q.push_back(mk(8, 19, 1, 0, 0));
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        n = stim_q.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL first_valid[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            drive(i < n ? stim_q[i] : mk(0, 0, 0, 0, 0), i < n);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_glyph();
        logic [11:0] e;
        int n;
        stim_q.delete();
        for (int x = 8; x < 16; x++) stim_q.push_back(mk(x, 19, 1, 0, 0));
        n = stim_q.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL glyph_pixel[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            if (i >= 1 && i <= n) begin
                checks++;
                if ({font_codepoint, font_row} !== 12'h413)
                    $display("FAIL glyph_font_addr[%0d]: got %h expected 413", i - 1, {font_codepoint, font_row});
                else passed++;
            end
            drive(i < n ? stim_q[i] : mk(0, 0, 0, 0, 0), i < n);
            #1;
            if (i < n) begin
                checks++;
                if (tb_addr !== 12'd81) $display("FAIL glyph_tb_addr[%0d]: got %0d expected 81", i, tb_addr);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cursor();
        logic [11:0] e;
        int n;
        cursor_en = 1; cursor_col = 7'd2; cursor_row = 5'd1;
        stim_q.delete();
        for (int y = 29; y < 32; y++)
            for (int x = 15; x < 25; x++) stim_q.push_back(mk(x, y, 1, 0, 0));
        n = stim_q.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL cursor[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            drive(i < n ? stim_q[i] : mk(0, 0, 0, 0, 0), i < n);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_blink();
        logic [11:0] e;
        int n;
        stim_q.delete();
        add_pulses(31);
        stim_q.push_back(mk(16, 30, 1, 0, 0));
        add_pulses(1);
        stim_q.push_back(mk(16, 30, 1, 0, 0));
        add_pulses(32);
        stim_q.push_back(mk(17, 31, 1, 0, 0));
        add_pulses(31);
        for (int k = 0; k < 100; k++) stim_q.push_back(mk(0, 0, 0, 0, 1));
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        stim_q.push_back(mk(16, 30, 1, 0, 0));
        n = stim_q.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL blink[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            drive(i < n ? stim_q[i] : mk(0, 0, 0, 0, 0), i < n);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_border();
        logic [11:0] e;
        int n;
        cursor_en = 0;
        stim_q.delete();
        stim_q.push_back(mk(640, 0, 1, 1, 0));
        stim_q.push_back(mk(700, 10, 1, 1, 1));
        stim_q.push_back(mk(0, 480, 1, 0, 1));
        for (int x = 0; x < 8; x++) stim_q.push_back(mk(x, 0, 1, x[0], 0));
        stim_q.push_back(mk(639, 479, 1, 0, 0));
        stim_q.push_back(mk(100, 100, 0, 1, 1));
        stim_q.push_back(mk(640, 20, 1, 0, 1));
        n = stim_q.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL border[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            drive(i < n ? stim_q[i] : mk(0, 0, 0, 0, 0), i < n);
            #1;
            if (i < n) begin
                checks++;
                if (tb_addr !== 12'(exp_addr(stim_q[i])))
                    $display("FAIL border_tb_addr[%0d]: got %0d expected %0d", i, tb_addr, exp_addr(stim_q[i]));
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        int n;
        cursor_en = 1; cursor_col = 7'd2; cursor_row = 5'd1;
        stim_q.delete();
        add_pulses(5);
        for (int x = 8; x < 16; x++) stim_q.push_back(mk(x, 19, 1, 1, 0));
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL pre_reset[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            drive(stim_q[i], 1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) $display("FAIL mid_reset_clear: got %h expected 000", obs);
        else passed++;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (obs !== 12'h000) $display("FAIL mid_reset_hold: got %h expected 000", obs);
        else passed++;
        rst_n = 1'b1;
        stim_q.delete();
        for (int x = 8; x < 16; x++) stim_q.push_back(mk(x, 19, 1, 0, 1));
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        add_pulses(31);
        stim_q.push_back(mk(16, 31, 1, 0, 0));
        add_pulses(1);
        stim_q.push_back(mk(16, 31, 1, 0, 0));
        n = stim_q.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i < 3) begin
                checks++;
                if (obs !== 12'h000) $display("FAIL post_reset_stale[%0d]: got %h expected 000", i, obs);
                else passed++;
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("FAIL post_reset[%0d]: got %h expected %h", i - 3, obs, e);
                else passed++;
            end
            drive(i < n ? stim_q[i] : mk(0, 0, 0, 0, 0), i < n);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tbuf[i] = 16'h0000;
            fmem[i] = 8'h00;
        end
        tbuf[81] = 16'h1F41;
        tbuf[0]  = 16'h2A42;
        fmem[16'h41 * FH + 3] = 8'h81;
        fmem[16'h42 * FH + 0] = 8'hA5;
        pix_x = '0; pix_y = '0; pix_active = 0; hsync_in = 0; vsync_in = 0;

        test_reset();
        test_glyph();
        test_cursor();
        test_blink();
        test_border();
        test_mid_reset();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
